// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one-hot columns, synchronises and debounces row
// returns, and emits one key event per press. Define KEYPAD_REPEAT_EN for hold-to-repeat.
module keypad_scanner #(
  parameter int unsigned NROWS           = 4,
  parameter int unsigned NCOLS           = 4,
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000,
  localparam int unsigned KW             = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NROWS-1:0] rows_in,
  output logic [NCOLS-1:0] cols_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KW-1:0]    key_code,
  output logic [3:0]       digit,
  output logic             is_digit,
  output logic             overrun
);

  localparam int unsigned RW      = $clog2(NROWS);
  localparam int unsigned CLW     = $clog2(NCOLS);
  localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (NROWS < 2 || NROWS > 8 || NCOLS < 2 || NCOLS > 8 || SCAN_CYCLES < 4 ||
      DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

  state_e           state_q, state_d;
  logic [NROWS-1:0] sync_q, rs_q;
  logic [CLW-1:0]   col_q, col_d;
  logic [NCOLS-1:0] cols_q, cols_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [KW-1:0]    code_q, code_d;
  logic [3:0]       digit_q, digit_d;
  logic             is_digit_q, is_digit_d;
  logic             overrun_q, overrun_d;

  logic             event_c;
  logic             row_hit_c;
  logic [RW-1:0]    low_row_c;
  logic [CLW-1:0]   col_next_c;
  logic [KW-1:0]    ev_code_c;
  logic [3:0]       ev_digit_c;
  logic             ev_is_digit_c;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HW      = $clog2(REP_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
`endif

  // Lowest-index asserted row wins when several rows return together.
  always_comb begin
    low_row_c = '0;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (rs_q[i]) low_row_c = RW'(i);
    end
  end

  assign row_hit_c  = rs_q[row_q];
  assign col_next_c = (col_q == CLW'(NCOLS - 1)) ? '0 : col_q + CLW'(1);

  // Key code and phone-layout digit for the latched row/column.
  always_comb begin
    int unsigned r, c;
    r = 32'(row_q);
    c = 32'(col_q);
    ev_code_c     = KW'(r * NCOLS + c);
    ev_digit_c    = 4'hF;
    ev_is_digit_c = 1'b0;
    if (r <= 32'd2 && c <= 32'd2) begin
      ev_digit_c    = 4'(r * 3 + c + 1);
      ev_is_digit_c = 1'b1;
    end else if (r == 32'd3 && c == 32'd1) begin
      ev_digit_c    = 4'h0;
      ev_is_digit_c = 1'b1;
    end
  end

  // Scan / debounce / held sequencing.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cols_d  = cols_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    event_c = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    hold_d  = '0;
    rep_d   = 1'b0;
`endif
    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == CW'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          if (rs_q != '0) begin
            row_d   = low_row_c;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d  = col_next_c;
            cols_d = NCOLS'(1) << col_next_c;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!row_hit_c) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          event_c = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (row_hit_c) begin
          cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if ((!rep_q && hold_q == HW'(REPEAT_DELAY - 1)) ||
              ( rep_q && hold_q == HW'(REPEAT_RATE - 1))) begin
            event_c = 1'b1;
            hold_d  = '0;
            rep_d   = 1'b1;
          end else begin
            hold_d = hold_q + HW'(1);
            rep_d  = rep_q;
          end
`endif
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          col_d   = col_next_c;
          cols_d  = NCOLS'(1) << col_next_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output slot: accept and load may coincide; an unaccepted slot drops new events.
  always_comb begin
    valid_d    = valid_q && !key_ready;
    code_d     = code_q;
    digit_d    = digit_q;
    is_digit_d = is_digit_q;
    overrun_d  = 1'b0;
    if (event_c) begin
      if (!valid_q || key_ready) begin
        valid_d    = 1'b1;
        code_d     = ev_code_c;
        digit_d    = ev_digit_c;
        is_digit_d = ev_is_digit_c;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      sync_q     <= '0;
      rs_q       <= '0;
      col_q      <= '0;
      cols_q     <= NCOLS'(1);
      row_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      digit_q    <= '0;
      is_digit_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_q     <= '0;
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= rows_in;
      rs_q       <= sync_q;
      col_q      <= col_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      digit_q    <= digit_d;
      is_digit_q <= is_digit_d;
      overrun_q  <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      hold_q     <= hold_d;
      rep_q      <= rep_d;
`endif
    end
  end

  assign cols_out  = cols_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign digit     = digit_q;
  assign is_digit  = is_digit_q;
  assign overrun   = overrun_q;

endmodule
